// File: rtl/rsp_s2_dma_pkg.sv
// Shared types and default widths for the S2 prep DMA schedulers.
package rsp_s2_dma_pkg;

  localparam int unsigned DEF_AW           = 32;
  localparam int unsigned DEF_OUT_BITS     = 8;
  localparam int unsigned DEF_TIMEOUT_BITS = 24;
  localparam int unsigned LEN_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ERR   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rsp_s2_dma_rd_sched_if.sv
// Requester command bus plus AXI AR channel and burst-completion strobe.
interface rsp_s2_dma_rd_sched_if
  import rsp_s2_dma_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_ready;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [AW-1:0]         ar_addr;
  logic [LEN_W-1:0]      ar_len;
  logic [IDW-1:0]        ar_id;

  logic                  r_done;

  modport master (
    input  req_valid, req_addr, req_len, ar_ready, r_done,
    output req_ready, ar_valid, ar_addr, ar_len, ar_id
  );

  modport slave (
    output req_valid, req_addr, req_len, ar_ready, r_done,
    input  req_ready, ar_valid, ar_addr, ar_len, ar_id
  );

endinterface

// File: rtl/rsp_s2_dma_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rsp_s2_dma_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c
);

  logic [IW-1:0] cand;
  logic          found;

  // N is a power of two, so IW-bit addition wraps exactly mod N.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IW'(k);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx_c        = cand;
        gnt_c[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsp_s2_dma_rd_sched.sv
// Round-robin AXI read-command scheduler with outstanding-burst limit,
// stalled-response timeout and drain-on-disable.
module rsp_s2_dma_rd_sched
  import rsp_s2_dma_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned IDW          = $clog2(NREQ),
  parameter int unsigned OUT_BITS     = DEF_OUT_BITS,
  parameter int unsigned TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_en,
  input  logic [OUT_BITS-1:0]     cfg_outs_max,
  input  logic [TIMEOUT_BITS-1:0] cfg_timeout_cnt,
  rsp_s2_dma_rd_sched_if.master   bus,
  output logic [OUT_BITS-1:0]     outs,
  output logic                    idle,
  output logic                    err_timeout,
  output logic                    err_underflow
);

  sched_state_e            state;
  logic [IDW-1:0]          rr_ptr;
  logic [TIMEOUT_BITS-1:0] tmo_cnt;

  logic [NREQ-1:0]         pick_gnt_c;
  logic [IDW-1:0]          pick_idx_c;
  logic [AW-1:0]           sel_addr_c;
  logic [LEN_W-1:0]        sel_len_c;
  logic                    hs_c;
  logic                    can_issue_c;
  logic                    underflow_c;
  logic [OUT_BITS-1:0]     outs_next_c;

  rsp_s2_dma_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c)
  );

  // Command fields of the current round-robin winner.
  always_comb begin
    sel_addr_c = '0;
    sel_len_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx_c == IDW'(i)) begin
        sel_addr_c = bus.req_addr[i*AW +: AW];
        sel_len_c  = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Outstanding-count update; a completion with nothing in flight is an underflow.
  always_comb begin
    hs_c        = bus.ar_valid & bus.ar_ready;
    can_issue_c = cfg_en && (|bus.req_valid) && (outs < cfg_outs_max) && !err_timeout;
    outs_next_c = outs;
    underflow_c = 1'b0;
    if (hs_c && !bus.r_done) begin
      outs_next_c = outs + OUT_BITS'(1);
    end else if (!hs_c && bus.r_done) begin
      if (outs == '0) underflow_c = 1'b1;
      else            outs_next_c = outs - OUT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      tmo_cnt       <= cfg_timeout_cnt;
      bus.req_ready <= '0;
      bus.ar_valid  <= 1'b0;
      bus.ar_addr   <= '0;
      bus.ar_len    <= '0;
      bus.ar_id     <= '0;
      outs          <= '0;
      idle          <= 1'b1;
      err_timeout   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      outs          <= outs_next_c;
      if (underflow_c) err_underflow <= 1'b1;

      // Timeout only runs while bursts are in flight and none is completing.
      if (bus.r_done || outs == '0)  tmo_cnt     <= cfg_timeout_cnt;
      else if (tmo_cnt != '0)        tmo_cnt     <= tmo_cnt - TIMEOUT_BITS'(1);
      else                           err_timeout <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (err_timeout) begin
            state <= ST_ERR;
            idle  <= 1'b0;
          end else if (can_issue_c) begin
            state         <= ST_ISSUE;
            bus.ar_valid  <= 1'b1;
            bus.ar_addr   <= sel_addr_c;
            bus.ar_len    <= sel_len_c;
            bus.ar_id     <= pick_idx_c;
            bus.req_ready <= pick_gnt_c;
            idle          <= 1'b0;
          end else begin
            idle <= (outs_next_c == '0);
          end
        end
        ST_ISSUE: begin
          idle <= 1'b0;
          if (hs_c) begin
            bus.ar_valid <= 1'b0;
            rr_ptr       <= bus.ar_id + IDW'(1);
            if (err_timeout) begin
              state <= ST_ERR;
            end else begin
              state <= ST_IDLE;
              idle  <= (outs_next_c == '0);
            end
          end
        end
        ST_ERR: begin
          idle <= 1'b0;
          if (!cfg_en && outs == '0) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b0;
            idle        <= (outs_next_c == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_s2_dma_rd_sched.sv
// Directed self-checking bench for rsp_s2_dma_rd_sched.
module tb_rsp_s2_dma_rd_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned IDW  = 2;
  localparam int unsigned OB   = 8;
  localparam int unsigned TB   = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [OB-1:0] cfg_outs_max;
  logic [TB-1:0] cfg_timeout_cnt;
  logic [OB-1:0] outs;
  logic          idle;
  logic          err_timeout;
  logic          err_underflow;

  int checks = 0;
  int errors = 0;

  rsp_s2_dma_rd_sched_if #(.NREQ(NREQ), .AW(AW), .IDW(IDW)) bus ();

  rsp_s2_dma_rd_sched #(
    .NREQ(NREQ), .AW(AW), .IDW(IDW), .OUT_BITS(OB), .TIMEOUT_BITS(TB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_en          (cfg_en),
    .cfg_outs_max    (cfg_outs_max),
    .cfg_timeout_cnt (cfg_timeout_cnt),
    .bus             (bus),
    .outs            (outs),
    .idle            (idle),
    .err_timeout     (err_timeout),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] a_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [7:0] len_of(input int i);
    return 8'(2 * i + 1);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ar_valid"},  32'(bus.ar_valid), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_ar_addr"},   32'(bus.ar_addr), 32'd0);
    chk({tag, "_ar_len"},    32'(bus.ar_len), 32'd0);
    chk({tag, "_ar_id"},     32'(bus.ar_id), 32'd0);
    chk({tag, "_outs"},      32'(outs), 32'd0);
    chk({tag, "_idle"},      32'(idle), 32'd1);
    chk({tag, "_err_to"},    32'(err_timeout), 32'd0);
    chk({tag, "_err_uf"},    32'(err_underflow), 32'd0);
  endtask

  initial begin
    int hs_cnt;
    int rdy_cnt;

    rst_n           = 1'b0;
    cfg_en          = 1'b0;
    cfg_outs_max    = 8'd8;
    cfg_timeout_cnt = 24'd1000;
    bus.req_valid   = '0;
    bus.ar_ready    = 1'b0;
    bus.r_done      = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_addr[i*AW +: AW] = a_of(i);
      bus.req_len[i*8 +: 8]    = len_of(i);
    end

    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Round-robin with ar_ready tied high: one burst every two cycles
    cfg_en        = 1'b1;
    bus.req_valid = 4'hF;
    bus.ar_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_valid", 32'(bus.ar_valid), 32'd1);
      chk("rr_id",    32'(bus.ar_id), 32'(k % 4));
      chk("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      chk("rr_addr",  32'(bus.ar_addr), a_of(k % 4));
      chk("rr_len",   32'(bus.ar_len), 32'(len_of(k % 4)));
      tick();
      chk("rr_gap",       32'(bus.ar_valid), 32'd0);
      chk("rr_ready_low", 32'(bus.req_ready), 32'd0);
      chk("rr_outs",      32'(outs), 32'(k + 1));
    end
    bus.req_valid = '0;
    bus.r_done    = 1'b1;
    repeat (5) tick();
    bus.r_done = 1'b0;
    chk("rr_drain_outs", 32'(outs), 32'd0);
    chk("rr_drain_idle", 32'(idle), 32'd1);
    chk("rr_no_uf",      32'(err_underflow), 32'd0);

    // Outstanding limit of two
    cfg_outs_max  = 8'd2;
    bus.req_valid = 4'hF;
    hs_cnt = 0;
    repeat (8) begin
      tick();
      if (bus.ar_valid) hs_cnt++;
    end
    chk("lim_hs",    32'(hs_cnt), 32'd2);
    chk("lim_outs",  32'(outs), 32'd2);
    chk("lim_valid", 32'(bus.ar_valid), 32'd0);
    bus.r_done = 1'b1;
    tick();
    bus.r_done = 1'b0;
    chk("lim_rdone_outs", 32'(outs), 32'd1);
    hs_cnt = 0;
    repeat (6) begin
      tick();
      if (bus.ar_valid) begin
        hs_cnt++;
        chk("lim_third_id", 32'(bus.ar_id), 32'd3);
      end
    end
    chk("lim_third_hs",   32'(hs_cnt), 32'd1);
    chk("lim_third_outs", 32'(outs), 32'd2);
    bus.req_valid = '0;
    bus.r_done    = 1'b1;
    tick();
    bus.r_done = 1'b0;
    chk("lim_left_outs", 32'(outs), 32'd1);

    // Back-pressure: ar_ready low five cycles, then handshake together with r_done
    cfg_outs_max  = 8'd8;
    bus.ar_ready  = 1'b0;
    bus.req_valid = 4'b0100;
    tick();
    chk("bp_valid", 32'(bus.ar_valid), 32'd1);
    chk("bp_id",    32'(bus.ar_id), 32'd2);
    chk("bp_ready", 32'(bus.req_ready), 32'b0100);
    rdy_cnt = $countones(bus.req_ready);
    bus.req_valid = '0;
    repeat (5) begin
      tick();
      chk("bp_hold_valid", 32'(bus.ar_valid), 32'd1);
      chk("bp_hold_id",    32'(bus.ar_id), 32'd2);
      chk("bp_hold_addr",  32'(bus.ar_addr), a_of(2));
      chk("bp_hold_len",   32'(bus.ar_len), 32'(len_of(2)));
      rdy_cnt += $countones(bus.req_ready);
    end
    chk("bp_one_pulse", 32'(rdy_cnt), 32'd1);
    bus.ar_ready = 1'b1;
    bus.r_done   = 1'b1;
    tick();
    bus.r_done = 1'b0;
    chk("bp_hs_valid", 32'(bus.ar_valid), 32'd0);
    chk("bp_sim_outs", 32'(outs), 32'd1);
    bus.r_done = 1'b1;
    tick();
    bus.r_done = 1'b0;
    chk("bp_empty", 32'(outs), 32'd0);

    // Timeout: err_timeout rises 11 cycles after outs becomes 1
    cfg_timeout_cnt = 24'd10;
    bus.req_valid   = 4'b0001;
    tick();
    chk("to_grant_id",    32'(bus.ar_id), 32'd0);
    chk("to_grant_valid", 32'(bus.ar_valid), 32'd1);
    bus.req_valid = '0;
    tick();
    chk("to_outs", 32'(outs), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("to_wait", 32'(err_timeout), 32'd0);
    end
    tick();
    chk("to_set", 32'(err_timeout), 32'd1);
    bus.req_valid = 4'hF;
    repeat (3) begin
      tick();
      chk("err_noissue", 32'(bus.ar_valid), 32'd0);
    end
    chk("err_idle", 32'(idle), 32'd0);
    cfg_en        = 1'b0;
    bus.req_valid = '0;
    bus.r_done    = 1'b1;
    tick();
    bus.r_done = 1'b0;
    chk("err_rdone_outs", 32'(outs), 32'd0);
    chk("err_hold",       32'(err_timeout), 32'd1);
    chk("err_hold_idle",  32'(idle), 32'd0);
    tick();
    chk("err_clear",      32'(err_timeout), 32'd0);
    chk("err_exit_idle",  32'(idle), 32'd1);

    // Underflow
    bus.r_done = 1'b1;
    tick();
    bus.r_done = 1'b0;
    chk("uf_outs", 32'(outs), 32'd0);
    chk("uf_flag", 32'(err_underflow), 32'd1);
    chk("uf_idle", 32'(idle), 32'd1);

    // Reset asserted mid-ISSUE
    cfg_en        = 1'b1;
    bus.ar_ready  = 1'b0;
    bus.req_valid = 4'b0010;
    tick();
    chk("mid_valid", 32'(bus.ar_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n         = 1'b1;
    bus.req_valid = '0;
    chk_reset_vals("mid_rst");

    // Drain: cfg_en dropped with three bursts in flight
    cfg_timeout_cnt = 24'd1000;
    bus.ar_ready    = 1'b1;
    bus.req_valid   = 4'hF;
    repeat (6) tick();
    chk("dr_outs", 32'(outs), 32'd3);
    cfg_en = 1'b0;
    repeat (4) begin
      tick();
      chk("dr_noissue", 32'(bus.ar_valid), 32'd0);
    end
    chk("dr_idle_pre", 32'(idle), 32'd0);
    bus.r_done = 1'b1;
    tick();
    chk("dr_outs2", 32'(outs), 32'd2);
    chk("dr_idle2", 32'(idle), 32'd0);
    tick();
    chk("dr_outs1", 32'(outs), 32'd1);
    chk("dr_idle1", 32'(idle), 32'd0);
    tick();
    bus.r_done = 1'b0;
    chk("dr_outs0", 32'(outs), 32'd0);
    chk("dr_idle0", 32'(idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsp_s2_dma_rd_sched.md
# rsp_s2_dma_rd_sched

Read-command scheduler for the S2 prep DMA. It arbitrates round-robin among NREQ read requesters and issues one AXI read-address beat at a time. Issue is gated by a global outstanding-burst limit, and every burst is tracked until its last read beat returns. A stalled-response timeout and a clean drain on disable are provided. The block sits between the per-channel DMA engines and the shared AXI AR channel.

## Interface
- NREQ, 4, number of requesters (power of two, 2..8)
- AW, 32, address width
- IDW, 2, AXI ID width, equal to log2(NREQ)
- OUT_BITS, 8, outstanding counter width
- TIMEOUT_BITS, 24, timeout counter width
- clk  in  1  clock, single domain
- rst_n  in  1  reset, synchronous, active-low
- cfg_en  in  1  enable new issue; deassert to drain
- cfg_outs_max  in  OUT_BITS  max bursts in flight (0 blocks issue)
- cfg_timeout_cnt  in  TIMEOUT_BITS  cycles without completion before timeout
- req_valid  in  NREQ  per-requester command pending
- req_addr  in  NREQ*AW  packed start addresses, requester i at [i*AW +: AW]
- req_len  in  NREQ*8  packed AXI burst lengths (beats-1)
- req_ready  out  NREQ  one-cycle pop pulse to the granted requester
- ar_valid / ar_ready  out / in  1  AXI AR handshake
- ar_addr  out  AW  burst start address
- ar_len  out  8  burst length
- ar_id  out  IDW  granted requester index
- r_done  in  1  rvalid & rready & rlast
- outs  out  OUT_BITS  bursts in flight
- idle  out  1  state IDLE and outs==0
- err_timeout  out  1  sticky timeout flag
- err_underflow  out  1  sticky flag for r_done seen with outs==0

## Operation
- States: IDLE, ISSUE, ERR.
- IDLE -> ISSUE when all of the following hold: cfg_en=1, |req_valid, outs < cfg_outs_max, err_timeout=0.
  - Winner = first set req_valid at or after rr_ptr, wrapping.
  - ar_addr, ar_len and ar_id = winner are registered on that edge.
- ISSUE:
  - ar_valid=1 and req_ready[ar_id]=1 on the first ISSUE cycle only.
  - ar_* are held stable until ar_ready.
  - On the handshake: outs+1, rr_ptr <= ar_id+1 (mod NREQ), then go to IDLE, or to ERR if err_timeout was set meanwhile.
- ERR: no issue. Exit to IDLE only when cfg_en=0 and outs==0; that exit also clears err_timeout.
- Requester contract: hold req_valid, req_addr and req_len stable until req_ready, then deassert or present the next command.
- Outstanding counter:
  - outs_next = outs + issue - r_done.
  - Issue and completion in the same cycle leave outs unchanged.
  - r_done with outs==0 leaves outs at 0 and sets err_underflow. err_underflow is cleared only by reset.
- Timeout counter:
  - Reloads to cfg_timeout_cnt on reset, on any r_done, and whenever outs==0.
  - Otherwise decrements while outs!=0.
  - Reaching 0 while outs!=0 sets err_timeout.
- cfg_en falling:
  - An ISSUE in progress completes; AXI valid is never withdrawn.
  - No new grants. idle rises once outs reaches 0.
- cfg_outs_max is lowered below outs: no new issue until outs < cfg_outs_max; the count is never forced.

## Timing
- Reset values:
  - req_ready=0, ar_valid=0, ar_addr=0, ar_len=0, ar_id=0
  - outs=0, idle=1, err_timeout=0, err_underflow=0
  - rr_ptr=0, state IDLE, timeout counter=cfg_timeout_cnt
- Grant latency: qualifying req_valid sampled at edge N gives ar_valid and req_ready at cycle N+1.
- Throughput: with ar_ready tied high, one burst every 2 cycles.
- All outputs are registered.
- outs and idle reflect the handshake or r_done one cycle after the edge on which it occurred.
- err_timeout is asserted one cycle after the counter reaches 0.
- Reset asserted mid-ISSUE: ar_valid drops on the next edge. The system resets the AXI slave alongside this block.

## Structure
- Package rsp_s2_dma_pkg holds:
  - the state enum (IDLE/ISSUE/ERR)
  - default widths AW, OUT_BITS, TIMEOUT_BITS
- Sub-module rsp_s2_dma_rr_pick: combinational round-robin picker.
  - Inputs: req vector and pointer. Outputs: one-hot grant and encoded index.
  - Reusable by the write scheduler.
- Outstanding and timeout counters are inline.

## Test plan
- **Round-robin:** req_valid=4'b1111, ar_ready=1, cfg_outs_max=8 -> ar_id sequence 0,1,2,3,0; one burst per 2 cycles; req_ready one-hot, aligned to the first ar_valid cycle.
- **Limit:** cfg_outs_max=2, no r_done -> exactly 2 handshakes, outs=2, ar_valid stays 0. One r_done -> a third burst issues and outs returns to 2.
- **Back-pressure and simultaneity:** ar_ready low for 5 cycles -> ar_addr, ar_len, ar_id stable and req_ready pulses once. r_done on the handshake cycle -> outs unchanged.
- **Timeout:** cfg_timeout_cnt=10, one burst issued, no r_done -> err_timeout rises 11 cycles after outs becomes 1; state ERR. cfg_en=0 plus r_done -> IDLE, err_timeout=0.
- **Underflow and reset:** r_done with outs=0 -> outs stays 0, err_underflow=1. rst_n=0 for one cycle mid-ISSUE -> all outputs return to reset values next cycle.
- **Drain:** cfg_en dropped while outs=3 -> no new ar_valid; idle rises one cycle after the third r_done.
